irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 139 +++++++++++++
 tb/tb_irq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Wishbone interrupt controller: per-source synchronizer + rising-edge latch into
// PENDING, MASK gating, and a two-state arbiter that presents one cause at a time.

module irq_sync_lane #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // prev_q resets to 0, so a source already high at release still yields one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
endmodule

module irq_ctrl #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             STB,
  input  logic             WE,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK,
  input  logic [N_SRC-1:0] src_irq,
  output logic             INT,
  output logic [31:0]      CAUSE
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, ASSERT} state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  sel;
    logic [31:0] data;
  } bus_req_t;

  bus_req_t         req;
  logic             accept;
  logic [31:0]      rd_data;
  logic [N_SRC-1:0] rise, pending_q, mask_q, active, w1c;
  state_e           state_q, state_d;
  logic [IW-1:0]    cause_q, cause_d, lowest;
  logic             unused_bits;

  irq_sync_lane #(.STAGES(SYNC_STAGES)) u_lane [N_SRC-1:0] (
    .clk      (clk),
    .rst      (rst),
    .async_in (src_irq),
    .rise     (rise)
  );

  assign req         = '{wr: WE, sel: ADDR[3:2], data: DAT_I};
  assign accept      = STB & ~ACK;
  assign w1c         = (accept && req.wr && req.sel == 2'd0) ? req.data[N_SRC-1:0] : '0;
  assign active      = pending_q & mask_q;
  assign unused_bits = ^{ADDR[31:4], ADDR[1:0], req};

  always_comb begin
    rd_data = '0;
    case (req.sel)
      2'd0: rd_data = 32'(pending_q);
      2'd1: rd_data = 32'(mask_q);
      2'd2: rd_data = 32'(cause_q);
      2'd3: rd_data = {30'd0, state_q == ASSERT, INT};
      default: rd_data = '0;
    endcase
  end

  // Bus slave and register file; a new edge beats a same-edge W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ACK       <= 1'b0;
      DAT_O     <= '0;
      mask_q    <= '0;
      pending_q <= '0;
    end else begin
      ACK       <= accept;
      DAT_O     <= accept ? rd_data : '0;
      pending_q <= (pending_q & ~w1c) | rise;
      if (accept && req.wr && req.sel == 2'd1) mask_q <= req.data[N_SRC-1:0];
    end
  end

  always_comb begin
    lowest = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (active[i]) lowest = IW'(i);
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (|active) begin
          state_d = ASSERT;
          cause_d = lowest;
        end
      end
      ASSERT: begin
        // cause is frozen; leave only when it is cleared or masked
        if (!(pending_q[cause_q] && mask_q[cause_q])) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= '0;
      INT     <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      INT     <= (state_d == ASSERT);
    end
  end

  assign CAUSE = 32'(cause_q);
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic, every cycle checked
// against an edge-history reference model.

module tb_irq_ctrl;
  localparam int N = 8;
  localparam int S = 2;
  localparam int unsigned FULL = 32'hFF;

  logic          clk = 1'b0, rst = 1'b1, STB = 1'b0, WE = 1'b0;
  logic [31:0]   ADDR = '0, DAT_I = '0;
  logic [31:0]   DAT_O, CAUSE;
  logic          ACK, INT;
  logic [N-1:0]  src_irq = '0;

  irq_ctrl #(.N_SRC(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .STB(STB), .WE(WE), .ADDR(ADDR), .DAT_I(DAT_I),
    .DAT_O(DAT_O), .ACK(ACK), .src_irq(src_irq), .INT(INT), .CAUSE(CAUSE)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // reference model state
  int unsigned m_pend, m_mask, m_cause, m_dato;
  bit          m_int, m_ack;
  int unsigned hist[$];   // src samples, hist[0] = most recent edge

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned lowest(input int unsigned v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_cause = 0; m_dato = 0; m_int = 0; m_ack = 0;
    hist = {};
    repeat (S + 2) hist.push_back(0);
  endtask

  task automatic model_edge();
    int unsigned rise, w1c, nmask, ndato, ncause, npend;
    bit nack, nint;
    if (rst) begin model_reset(); return; end
    hist.push_front(int'(src_irq));
    void'(hist.pop_back());
    // a source pends once its synchronized copy shows a 0->1 step
    rise  = hist[S] & ~hist[S+1] & FULL;
    w1c   = 0; nmask = m_mask; nack = 0; ndato = 0;
    if (STB && !m_ack) begin
      nack = 1;
      case (ADDR[3:2])
        2'd0: ndato = m_pend;
        2'd1: ndato = m_mask;
        2'd2: ndato = m_cause;
        default: ndato = m_int ? 3 : 0;
      endcase
      if (WE && ADDR[3:2] == 2'd0) w1c   = DAT_I & FULL;
      if (WE && ADDR[3:2] == 2'd1) nmask = DAT_I & FULL;
    end
    npend = (m_pend & ~w1c) | rise;
    nint = m_int; ncause = m_cause;
    if (!m_int) begin
      if ((m_pend & m_mask) != 0) begin nint = 1; ncause = lowest(m_pend & m_mask); end
    end else if (((m_pend >> m_cause) & (m_mask >> m_cause) & 1) == 0) nint = 0;
    m_pend = npend; m_mask = nmask; m_ack = nack; m_dato = ndato;
    m_int = nint; m_cause = ncause;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("ack", {31'd0, ACK}, {31'd0, m_ack});
    check("dat_o", DAT_O, m_dato);
    check("int", {31'd0, INT}, {31'd0, m_int});
    check("cause", CAUSE, m_cause);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    ADDR = a; DAT_I = d; WE = 1; STB = 1;
    step();
    STB = 0; WE = 0;
    step();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    ADDR = a; WE = 0; STB = 1;
    step();
    d = DAT_O;
    STB = 0;
    step();
  endtask

  initial begin
    logic [31:0] d;
    model_reset();
    repeat (3) step();
    check("rst_int", {31'd0, INT}, 32'd0);
    check("rst_ack", {31'd0, ACK}, 32'd0);
    check("rst_cause", CAUSE, 32'd0);
    rst = 0;
    repeat (2) step();

    // single source, partially masked
    bus_write(32'h4, 32'h0A);
    src_irq[3] = 1;
    repeat (3) step();
    check("e3_int", {31'd0, INT}, 32'd0);
    step();
    check("e4_int", {31'd0, INT}, 32'd1);
    check("e4_cause", CAUSE, 32'd3);
    bus_read(32'h0, d);
    check("pend_08", d, 32'h08);
    src_irq = '0;
    bus_write(32'h0, 32'h08);
    repeat (6) step();
    check("cleared_int", {31'd0, INT}, 32'd0);

    // two sources same cycle: lowest wins, gap cycle, then next
    bus_write(32'h4, 32'hFF);
    src_irq = 8'h0A;
    repeat (4) step();
    check("dual_cause", CAUSE, 32'd1);
    check("dual_int", {31'd0, INT}, 32'd1);
    bus_write(32'h0, 32'h02);
    check("gap_int", {31'd0, INT}, 32'd0);
    step();
    check("next_int", {31'd0, INT}, 32'd1);
    check("next_cause", CAUSE, 32'd3);
    src_irq = '0;
    bus_write(32'h0, 32'h08);
    repeat (6) step();

    // cause held while a lower index arrives
    src_irq[3] = 1;
    repeat (4) step();
    check("hold_cause0", CAUSE, 32'd3);
    src_irq[0] = 1;
    repeat (5) step();
    check("hold_cause1", CAUSE, 32'd3);
    bus_write(32'h0, 32'h08);
    check("hold_gap", {31'd0, INT}, 32'd0);
    step();
    check("hold_new_cause", CAUSE, 32'd0);
    src_irq = '0;
    bus_write(32'h0, 32'h01);
    repeat (6) step();

    // masked source pends; unmask triggers arbitration
    bus_write(32'h4, 32'h0);
    src_irq[5] = 1;
    repeat (5) step();
    check("masked_int", {31'd0, INT}, 32'd0);
    bus_read(32'h0, d);
    check("masked_pend", d, 32'h20);
    ADDR = 32'h4; DAT_I = 32'h20; WE = 1; STB = 1;
    step();
    check("unmask_a0", {31'd0, INT}, 32'd0);
    STB = 0; WE = 0;
    step();
    check("unmask_int", {31'd0, INT}, 32'd1);
    check("unmask_cause", CAUSE, 32'd5);
    src_irq = '0;
    bus_write(32'h4, 32'h0);
    bus_write(32'h0, 32'h20);
    repeat (6) step();

    // W1C lands on the same edge as the new set: set wins
    src_irq[2] = 1;
    step(); step();
    ADDR = 32'h0; DAT_I = 32'h04; WE = 1; STB = 1;
    step();
    STB = 0; WE = 0;
    step();
    bus_read(32'h0, d);
    check("set_wins", d, 32'h04);

    // back-to-back strobe gives ACK every other cycle
    ADDR = 32'h8; STB = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("b2b_ack", {31'd0, ACK}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    STB = 0;
    step();

    // reset while asserting with a bus cycle open
    bus_write(32'h4, 32'h04);
    step();
    check("pre_rst_int", {31'd0, INT}, 32'd1);
    ADDR = 32'h0; STB = 1;
    step();
    #2 rst = 1;
    model_reset();
    #1;
    check("arst_int", {31'd0, INT}, 32'd0);
    check("arst_ack", {31'd0, ACK}, 32'd0);
    check("arst_dato", DAT_O, 32'd0);
    STB = 0;
    repeat (2) step();
    rst = 0;
    repeat (2) step();
    check("post_rst_ack", {31'd0, ACK}, 32'd0);
    bus_read(32'h0, d);
    check("post_rst_pend", d, 32'h0);
    bus_read(32'h4, d);
    check("post_rst_mask", d, 32'h0);
    // src[2] held high through reset pends exactly once, then never again
    repeat (2) step();
    bus_read(32'h0, d);
    check("held_pend", d, 32'h04);
    bus_write(32'h0, 32'h04);
    repeat (4) step();
    bus_read(32'h0, d);
    check("no_repend", d, 32'h0);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) == 0) src_irq[$urandom_range(0, N-1)] ^= 1'b1;
      STB = ($urandom_range(0, 2) == 0);
      WE  = $urandom_range(0, 1);
      ADDR  = $urandom;
      DAT_I = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1;
        model_reset();
      end else rst = 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
